// File: rtl/result_view_controller_pkg.sv
// Shared encodings for the calculator output-stage view sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package result_view_controller_pkg;

    localparam logic [1:0] VIEW_ARITH = 2'b00;
    localparam logic [1:0] VIEW_LOGIC = 2'b01;
    localparam logic [1:0] VIEW_CMP   = 2'b10;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    typedef enum logic {
        DB_IDLE    = 1'b0,
        DB_PRESSED = 1'b1
    } db_state_e;

    // ARITH -> LOGIC -> CMP -> ARITH; the unused code 2'b11 falls back to ARITH
    function automatic logic [1:0] next_view(input logic [1:0] v);
        case (v)
            VIEW_ARITH: next_view = VIEW_LOGIC;
            VIEW_LOGIC: next_view = VIEW_CMP;
            default:    next_view = VIEW_ARITH;
        endcase
    endfunction

    // LED one-hot for the view, ARITH in the MSB
    function automatic logic [2:0] view_onehot(input logic [1:0] v);
        case (v)
            VIEW_LOGIC: view_onehot = 3'b010;
            VIEW_CMP:   view_onehot = 3'b001;
            default:    view_onehot = 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/result_view_controller_key_debounce.sv
// Synchronizes one raw active-low pushbutton and emits one pulse per accepted press.
// Latency: pin low before edge k -> press_o high after edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none; the pulse is a single cycle and is never held.
module key_debounce
    import result_view_controller_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [15:0] CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

    logic        sync1_q;
    logic        sync2_q;
    db_state_e   state_q;
    logic [15:0] cnt_q;
    logic        press_q;

    // Synchronizer plus debounce FSM: the counter tracks the run length of the
    // level opposite to the current state; any sample of the other level restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            case (state_q)
                DB_IDLE: begin
                    if (sync2_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        state_q <= DB_PRESSED;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DB_PRESSED: begin
                    if (!sync2_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DB_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= DB_IDLE;
                end
            endcase
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/result_view_controller.sv
// Chooses which calculator result drives the hex display and LEDs (manual step / timed auto-scan).
// Latency: view/mode change one edge after a debounced pulse; disp_value/led lag view and sources by one cycle.
// Backpressure: none; pushbutton pulses and scan expiries are consumed in the cycle they occur.
module result_view_controller
    import result_view_controller_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [25:0] SCAN_CYCLES     = 26'd50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    input  logic [8:0] arith_result,
    input  logic [7:0] logic_result,
    input  logic [3:0] cmp_result,
    output logic [1:0] view_sel,
    output logic [8:0] disp_value,
    output logic [9:0] led
);

    localparam logic [25:0] SCAN_LAST = SCAN_CYCLES - 26'd1;

    logic        mode_press;
    logic        view_press;
    logic        scan_wrap;

    mode_e       mode_q,  mode_d;
    logic [25:0] timer_q, timer_d;
    logic [1:0]  view_q,  view_d;
    logic [8:0]  disp_q,  disp_d;
    logic [9:0]  led_q,   led_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_n[0]),
        .press_o (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_view (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_n[1]),
        .press_o (view_press)
    );

    // Next mode, view and scan timer; a key step and a timer expiry in the same
    // cycle merge into one step, and any step or mode change restarts the dwell.
    always_comb begin
        scan_wrap = (mode_q == MODE_AUTO) && (timer_q == SCAN_LAST);
        mode_d    = mode_q;
        if (mode_press) begin
            mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
        end
        view_d = (view_press || scan_wrap) ? next_view(view_q) : view_q;
        if ((mode_d != MODE_AUTO) || mode_press || view_press || scan_wrap) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 26'd1;
        end
    end

    // Output images, built from the current view so they trail view_sel by one cycle
    always_comb begin
        case (view_q)
            VIEW_LOGIC: disp_d = {1'b0, logic_result};
            VIEW_CMP:   disp_d = {5'b0, cmp_result};
            default:    disp_d = arith_result;
        endcase
        led_d = {(mode_q == MODE_AUTO), view_onehot(view_q), 2'b00,
                 (view_q == VIEW_CMP) ? cmp_result : 4'b0000};
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q  <= MODE_MANUAL;
            timer_q <= '0;
            view_q  <= VIEW_ARITH;
            disp_q  <= '0;
            led_q   <= 10'b01_0000_0000;
        end else begin
            mode_q  <= mode_d;
            timer_q <= timer_d;
            view_q  <= view_d;
            disp_q  <= disp_d;
            led_q   <= led_d;
        end
    end

    assign view_sel   = view_q;
    assign disp_value = disp_q;
    assign led        = led_q;

endmodule

// File: tb/tb_result_view_controller.sv
// Directed bench for result_view_controller with DEBOUNCE_CYCLES=4, SCAN_CYCLES=8.
// Latency: expectations are hand-timed against the active clock edge count.
// Backpressure: n/a.
module tb_result_view_controller;

    logic       clk;
    logic       rst_n;
    logic [1:0] key_n;
    logic [8:0] arith_result;
    logic [7:0] logic_result;
    logic [3:0] cmp_result;
    logic [1:0] view_sel;
    logic [8:0] disp_value;
    logic [9:0] led;

    int checks      = 0;
    int failures    = 0;
    int view_changes = 0;
    int base        = 0;
    logic [1:0] last_view = 2'b00;

    result_view_controller #(
        .DEBOUNCE_CYCLES (16'd4),
        .SCAN_CYCLES     (26'd8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_n        (key_n),
        .arith_result (arith_result),
        .logic_result (logic_result),
        .cmp_result   (cmp_result),
        .view_sel     (view_sel),
        .disp_value   (disp_value),
        .led          (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count view transitions, sampled away from the active edge
    always @(negedge clk) begin
        if (view_sel !== last_view) view_changes++;
        last_view = view_sel;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        key_n        = 2'b11;
        arith_result = 9'h000;
        logic_result = 8'h3C;
        cmp_result   = 4'hA;
        step(3);
        chk("reset_view", 32'(view_sel), 32'h0);
        chk("reset_disp", 32'(disp_value), 32'h0);
        chk("reset_led",  32'(led), 32'h100);

        rst_n        = 1'b1;
        arith_result = 9'h1A5;
        step(1);
        chk("arith_disp", 32'(disp_value), 32'h1A5);
        chk("arith_led",  32'(led), 32'h100);
        chk("arith_view", 32'(view_sel), 32'h0);

        // Clean key-1 press: pin low before edge k, pulse at k+5, view at k+6
        base     = view_changes;
        key_n[1] = 1'b0;
        step(6);
        chk("press_latency_pre", 32'(view_sel), 32'h0);
        step(1);
        chk("press_latency_step", 32'(view_sel), 32'h1);
        step(3);
        key_n[1] = 1'b1;
        step(10);
        chk("clean_view",  32'(view_sel), 32'h1);
        chk("clean_disp",  32'(disp_value), 32'h03C);
        chk("clean_led",   32'(led), 32'h080);
        chk("clean_steps", 32'(view_changes - base), 32'd1);

        // Bounce on press and on release: exactly one step
        base     = view_changes;
        key_n[1] = 1'b0; step(3);
        key_n[1] = 1'b1; step(1);
        key_n[1] = 1'b0; step(6);
        key_n[1] = 1'b1; step(2);
        key_n[1] = 1'b0; step(1);
        key_n[1] = 1'b1; step(10);
        chk("bounce_view",  32'(view_sel), 32'h2);
        chk("bounce_steps", 32'(view_changes - base), 32'd1);

        // Back to ARITH
        key_n[1] = 1'b0; step(10);
        key_n[1] = 1'b1; step(10);
        chk("wrap_to_arith", 32'(view_sel), 32'h0);

        // Enter AUTO: pin low before edge k, mode at k+6, led[9] at k+7, steps at k+14/22/30
        key_n[0] = 1'b0;
        step(8);
        chk("auto_led9", 32'(led[9]), 32'h1);
        chk("auto_view_start", 32'(view_sel), 32'h0);
        step(2);
        key_n[0] = 1'b1;
        step(4);
        chk("auto_k13", 32'(view_sel), 32'h0);
        step(1);
        chk("auto_k14", 32'(view_sel), 32'h1);
        step(7);
        chk("auto_k21", 32'(view_sel), 32'h1);
        step(1);
        chk("auto_k22", 32'(view_sel), 32'h2);
        step(1);
        chk("cmp_led_low", 32'(led[3:0]), 32'hA);
        chk("cmp_led_view", 32'(led[8:6]), 32'h1);
        chk("cmp_disp", 32'(disp_value), 32'h00A);
        step(6);
        chk("auto_k29", 32'(view_sel), 32'h2);
        step(1);
        chk("auto_k30", 32'(view_sel), 32'h0);

        // Key-1 pulse lands on the timer wrap at edge k+38: one step only
        base = view_changes;
        step(1);
        key_n[1] = 1'b0;
        step(6);
        chk("coinc_k37", 32'(view_sel), 32'h0);
        step(1);
        chk("coinc_k38", 32'(view_sel), 32'h1);
        step(1);
        key_n[1] = 1'b1;
        step(6);
        chk("coinc_k45", 32'(view_sel), 32'h1);
        step(1);
        chk("coinc_k46", 32'(view_sel), 32'h2);
        chk("coinc_steps", 32'(view_changes - base), 32'd2);

        // One-cycle reset mid-scan
        step(3);
        chk("prereset_led9", 32'(led[9]), 32'h1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_view", 32'(view_sel), 32'h0);
        chk("midrst_disp", 32'(disp_value), 32'h0);
        chk("midrst_led",  32'(led), 32'h100);
        rst_n = 1'b1;
        step(1);
        chk("postrst_disp", 32'(disp_value), 32'h1A5);
        chk("postrst_led",  32'(led), 32'h100);
        step(20);
        chk("postrst_manual_view", 32'(view_sel), 32'h0);
        chk("postrst_manual_led",  32'(led), 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
